// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_pipe datapath.
//   alu_op_t    : 3-bit opcode encoding presented on the opcode port
//   FLAG_*      : bit positions inside the 4-bit flag vector
//   alu_state_t : control states of the alu_pipe sequencer
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial-product step per cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : latch a/b, clear accumulator and step counter
//   a, b          : multiplicand, multiplier (sampled only on start)
//   done          : high during the cycle whose edge completes the last step
//   product_lo/hi : full product, valid while done is high
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;

  // r_lo starts as the multiplier and fills with product bits from the top as
  // the {r_hi, r_lo} pair shifts right each step.
  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  end

  // The final step is exposed combinationally so the consumer can register
  // the finished product on the same edge that would perform that step.
  assign done       = r_run && (r_cnt == CW'(WIDTH - 1));
  assign product_hi = w_sum[WIDTH:1];
  assign product_lo = {w_sum[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= a;
      r_hi    <= '0;
      r_lo    <= b;
    end else if (r_run) begin
      r_hi  <= product_hi;
      r_lo  <= product_lo;
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU between instruction decode and register writeback.
// Single-cycle logic/arith/shift ops, iterative multiply, registered result.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (opcode, a, b sampled on transfer)
//   opcode, a, b        : operation and operands; shifts use b[SHW-1:0]
//   out_valid/out_ready : result handshake
//   result, flags       : registered result and {N, V, C, Z}
//   busy                : multiply in progress
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  alu_state_t       r_state;
  logic [1:0]       r_sync;

  alu_op_t          w_op;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_mul_hi;
  logic [3:0]       w_mul_flags;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;

  // Two-stage release so in_ready rises on the second edge after reset lifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_op        = alu_op_t'(opcode);
  assign in_ready    = r_sync[1] &&
                       ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_op == OP_MUL);
  assign w_shamt     = b[SHW-1:0];

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk        (clk),
    .rst_n      (reset),
    .start      (w_mul_start),
    .a          (a),
    .b          (b),
    .done       (w_mul_done),
    .product_lo (w_mul_lo),
    .product_hi (w_mul_hi)
  );

  // Extra bit on each path captures carry/borrow/shifted-out bit.
  always_comb begin
    w_add = {1'b0, a} + {1'b0, b};
    w_sub = {1'b0, a} - {1'b0, b};
    w_shl = {1'b0, a} << w_shamt;
    w_shr = {a, 1'b0} >> w_shamt;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      default: w_res = '0;
    endcase
    w_flags         = '0;
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
    w_flags[FLAG_N] = w_res[WIDTH-1];
  end

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_Z] = (w_mul_lo == '0);
    w_mul_flags[FLAG_C] = |w_mul_hi;
    w_mul_flags[FLAG_V] = |w_mul_hi;
    w_mul_flags[FLAG_N] = w_mul_lo[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        // HOLD only accepts while out_ready is high, so an acceptance there
        // always coincides with the outgoing transfer.
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state   <= ST_MUL_BUSY;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              r_state   <= ST_HOLD;
              result    <= w_res;
              flags     <= w_flags;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL_BUSY: begin
          if (w_mul_done) begin
            r_state   <= ST_HOLD;
            result    <= w_mul_lo;
            flags     <= w_mul_flags;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  alu_pipe #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  typedef struct {
    alu_op_t    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] e_res;
  logic [3:0] e_flg;
  logic       acc;
  logic       rand_rdy = 1'b0;
  int         last_wait;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Called at a falling edge; evaluates both handshakes just before the
  // rising edge and returns at the next falling edge.
  task automatic cycle();
    exp_t e;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    #4;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got result %0h flags %0h expected none", result, flags);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", {24'd0, result}, {24'd0, e.res});
        chk("sb_flags", {28'd0, flags}, {28'd0, e.flg});
      end
    end
    if (in_valid && in_ready) begin
      sbq.push_back('{res: e_res, flg: e_flg});
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic issue(input alu_op_t op, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] er, input logic [3:0] ef);
    opcode   = op;
    a        = ia;
    b        = ib;
    e_res    = er;
    e_flg    = ef;
    in_valid = 1'b1;
    last_wait = 0;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      last_wait++;
      if (acc) break;
    end
    chk("accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    opcode   = 3'($urandom);
    a        = 8'($urandom);
    b        = 8'($urandom);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (sbq.size() == 0 && !out_valid) break;
      cycle();
    end
    chk("drain_empty", sbq.size(), 0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vt[1]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100};
    vt[2]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vt[3]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b1000};
    vt[4]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001};
    vt[5]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vt[6]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b1010};
    vt[7]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010};
    vt[8]  = '{OP_SHR, 8'h81, 8'h01, 8'h40, 4'b0010};
    vt[9]  = '{OP_SHL, 8'h81, 8'h00, 8'h81, 4'b1000};
    vt[10] = '{OP_SHR, 8'h80, 8'h07, 8'h01, 4'b0000};
    vt[11] = '{OP_SHL, 8'h03, 8'h07, 8'h80, 4'b1010};
    vt[12] = '{OP_SHR, 8'hF0, 8'h09, 8'h78, 4'b0000};
    vt[13] = '{OP_MUL, 8'd20, 8'd15, 8'h2C, 4'b0110};
    vt[14] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b0110};
    vt[15] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0111};
    vt[16] = '{OP_MUL, 8'h0C, 8'h0A, 8'h78, 4'b0000};
    vt[17] = '{OP_MUL, 8'h80, 8'h01, 8'h80, 4'b1000};
    vt[18] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 4'b0111};
    vt[19] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b0001};
    vt[20] = '{OP_MUL, 8'h00, 8'hFF, 8'h00, 4'b0001};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 3'd0;
    a         = 8'd0;
    b         = 8'd0;
    e_res     = 8'd0;
    e_flg     = 4'd0;
    #1 reset  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    cycle();
    chk("sync_edge1_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("sync_edge2_in_ready", {31'd0, in_ready}, 32'd1);

    // Table of vectors under random consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < NV; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flg);
    end
    drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;

    // Multiply latency with a request held off during the busy window
    issue(OP_MUL, 8'd20, 8'd15, 8'h2C, 4'b0110);
    opcode   = OP_ADD;
    a        = 8'h01;
    b        = 8'h01;
    e_res    = 8'h02;
    e_flg    = 4'b0000;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_out_valid_early", {31'd0, out_valid}, 32'd0);
      cycle();
    end
    chk("mul_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_busy_end", {31'd0, busy}, 32'd0);
    chk("mul_result", {24'd0, result}, 32'h2C);
    chk("mul_flags", {28'd0, flags}, 32'b0110);
    chk("hold_in_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    chk("hold_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    drain();

    // Back-to-back logic ops, no bubbles
    issue(OP_AND, 8'hCC, 8'hAA, 8'h88, 4'b1000);
    chk("b2b_wait_and", last_wait, 1);
    chk("b2b_valid_and", {31'd0, out_valid}, 32'd1);
    issue(OP_OR, 8'h0C, 8'h03, 8'h0F, 4'b0000);
    chk("b2b_wait_or", last_wait, 1);
    chk("b2b_valid_or", {31'd0, out_valid}, 32'd1);
    issue(OP_XOR, 8'h55, 8'h55, 8'h00, 4'b0001);
    chk("b2b_wait_xor", last_wait, 1);
    chk("b2b_valid_xor", {31'd0, out_valid}, 32'd1);
    cycle();
    chk("b2b_idle", {31'd0, out_valid}, 32'd0);
    drain();

    // Backpressure: held result, ignored request
    out_ready = 1'b0;
    issue(OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", {24'd0, result}, 32'h02);
      chk("bp_flags", {28'd0, flags}, 32'b0010);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      opcode   = OP_ADD;
      a        = 8'($urandom);
      b        = 8'($urandom);
      in_valid = 1'b1;
      cycle();
      chk("bp_no_accept", {31'd0, acc}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("bp_released", {31'd0, out_valid}, 32'd0);
    chk("bp_sb_empty", sbq.size(), 0);

    // Reset mid-multiply
    issue(OP_MUL, 8'd20, 8'd15, 8'h2C, 4'b0110);
    cycle();
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_result", {24'd0, result}, 32'd0);
    chk("mrst_flags", {28'd0, flags}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    sbq.delete();
    @(negedge clk);
    cycle();
    reset = 1'b1;
    cycle();
    chk("mrst_sync1", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("mrst_sync2", {31'd0, in_ready}, 32'd1);
    issue(OP_ADD, 8'd3, 8'd4, 8'd7, 4'b0000);
    chk("mrst_add_valid", {31'd0, out_valid}, 32'd1);
    chk("mrst_add_result", {24'd0, result}, 32'd7);
    drain();
    for (int i = 0; i < 12; i++) cycle();
    chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
